// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud encoding, oversampling constants and divisor helper
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  SAMPLE_LO   = 4'd6;
  localparam logic [3:0]  SAMPLE_HI   = 4'd12;
  localparam logic [7:0]  FRAME_TICKS = 8'd160;

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

  // Codes above the table all fall back to the fastest rate
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      BAUD_9600:  return 9600;
      BAUD_19200: return 19200;
      BAUD_38400: return 38400;
      BAUD_57600: return 57600;
      default:    return 115200;
    endcase
  endfunction

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - line input, rate select and received-byte outputs of the UART receiver
interface uart_byte_rx_if;

  logic [2:0] baud_set;
  logic       Rs232_Rx;
  logic [7:0] data_byte;
  logic       Rx_Done;
  logic       frame_err;
  logic       uart_state;

  modport master (
    input  baud_set, Rs232_Rx,
    output data_byte, Rx_Done, frame_err, uart_state
  );

  modport slave (
    output baud_set, Rs232_Rx,
    input  data_byte, Rx_Done, frame_err, uart_state
  );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - sample tick generator; period CLK_FREQ/(baud*OVERSAMPLE), cleared while disabled
module uart_baud_gen #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       enable,
  input  logic [2:0] baud_set,
  output logic       tick
);
  import uart_pkg::baud_div;
  import uart_pkg::baud_rate;

  localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, baud_rate(uart_pkg::BAUD_9600), OVERSAMPLE);
  localparam int unsigned CNT_W   = $clog2(DIV_MAX + 1);

  localparam logic [CNT_W-1:0] END_9600 =
    CNT_W'(baud_div(CLK_FREQ, baud_rate(uart_pkg::BAUD_9600), OVERSAMPLE) - 1);
  localparam logic [CNT_W-1:0] END_19200 =
    CNT_W'(baud_div(CLK_FREQ, baud_rate(uart_pkg::BAUD_19200), OVERSAMPLE) - 1);
  localparam logic [CNT_W-1:0] END_38400 =
    CNT_W'(baud_div(CLK_FREQ, baud_rate(uart_pkg::BAUD_38400), OVERSAMPLE) - 1);
  localparam logic [CNT_W-1:0] END_57600 =
    CNT_W'(baud_div(CLK_FREQ, baud_rate(uart_pkg::BAUD_57600), OVERSAMPLE) - 1);
  localparam logic [CNT_W-1:0] END_115200 =
    CNT_W'(baud_div(CLK_FREQ, baud_rate(uart_pkg::BAUD_115200), OVERSAMPLE) - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_end;

  always_comb begin
    div_end = END_115200;
    case (baud_set)
      uart_pkg::BAUD_9600:  div_end = END_9600;
      uart_pkg::BAUD_19200: div_end = END_19200;
      uart_pkg::BAUD_38400: div_end = END_38400;
      uart_pkg::BAUD_57600: div_end = END_57600;
      default:              div_end = END_115200;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst || !enable) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == div_end) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 16x oversampled UART byte receiver with 7-sample majority vote per bit
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic           Clk,
  input  logic           Rst,
  uart_byte_rx_if.master bus
);

  rx_state_t  state;
  logic       rx_s1, rx_s2, rx_s3;
  logic [2:0] sync_ok;
  logic [7:0] bps_cnt;
  logic [2:0] vote;
  logic [7:0] shift;
  logic [2:0] baud_lat;
  logic [7:0] data_byte_q;
  logic       rx_done_q, frame_err_q, busy_q;

  logic       tick;
  logic       fall;
  logic [3:0] bit_idx, sub;
  logic       in_window, bit_val;
  logic [2:0] vote_nxt;

  // sync_ok keeps the reset value of the synchronizer from faking an edge on a line held low
  assign fall      = sync_ok[2] & rx_s3 & ~rx_s2;
  assign bit_idx   = bps_cnt[7:4];
  assign sub       = bps_cnt[3:0];
  assign in_window = (sub >= SAMPLE_LO) && (sub <= SAMPLE_HI);
  assign vote_nxt  = vote + {2'b00, rx_s2};
  assign bit_val   = (vote_nxt >= 3'd4);

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_gen (
    .Clk      (Clk),
    .Rst      (Rst),
    .enable   (state == RECV),
    .baud_set (baud_lat),
    .tick     (tick)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_s3       <= 1'b1;
      sync_ok     <= '0;
      state       <= IDLE;
      bps_cnt     <= '0;
      vote        <= '0;
      shift       <= '0;
      baud_lat    <= '0;
      data_byte_q <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_s1       <= bus.Rs232_Rx;
      rx_s2       <= rx_s1;
      rx_s3       <= rx_s2;
      sync_ok     <= {sync_ok[1:0], 1'b1};
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= RECV;
            busy_q   <= 1'b1;
            bps_cnt  <= '0;
            vote     <= '0;
            baud_lat <= bus.baud_set;
          end
        end

        RECV: begin
          if (tick) begin
            bps_cnt <= bps_cnt + 8'd1;
            if (in_window) vote <= vote_nxt;
            if (bps_cnt == FRAME_TICKS - 8'd1) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
            // Last sample of each bit decides it; the vote restarts for the next bit
            if (sub == SAMPLE_HI) begin
              vote <= '0;
              if (bit_idx == 4'd0) begin
                if (bit_val) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                end
              end else if (bit_idx <= 4'd8) begin
                shift <= {bit_val, shift[7:1]};
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
                if (bit_val) begin
                  data_byte_q <= shift;
                  rx_done_q   <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                end
              end
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_byte  = data_byte_q;
  assign bus.Rx_Done    = rx_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.uart_state = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx (50 MHz instance plus 5 MHz instance for the rate sweep)
module tb_uart_byte_rx;

  localparam int DIV_A = 27;        // 50e6 / (115200*16)
  localparam int BIT_A = 16 * DIV_A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  uart_byte_rx_if ifa ();
  uart_byte_rx_if ifb ();

  uart_byte_rx #(.CLK_FREQ(50_000_000)) dut_a (.Clk(clk), .Rst(rst), .bus(ifa));
  uart_byte_rx #(.CLK_FREQ(5_000_000))  dut_b (.Clk(clk), .Rst(rst), .bus(ifb));

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic pa_prev = 1'b0, pb_prev = 1'b0;
  int   run_a = 0, run_b = 0, len_a = 0, len_b = 0;

  // 5 MHz divisors for baud_set 0..4: 32.55, 16.27, 8.13, 5.42, 2.71 truncated
  function automatic int div_b(input int sel);
    case (sel)
      0: return 32;
      1: return 16;
      2: return 8;
      3: return 5;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pa_prev = 1'b0;
      run_a   = 0;
    end else begin
      if (ifa.Rx_Done || ifa.frame_err) begin
        chk("a_pulse_excl", int'(ifa.Rx_Done & ifa.frame_err), 0);
        chk("a_pulse_width", int'(pa_prev), 0);
        if (q_a.size() == 0) chk("a_unexpected_pulse", 1, 0);
        else begin
          ea = q_a.pop_front();
          chk("a_kind_ferr", int'(ifa.frame_err), int'(ea.is_err));
          if (!ea.is_err) chk("a_data", int'(ifa.data_byte), int'(ea.data));
        end
      end
      pa_prev = ifa.Rx_Done | ifa.frame_err;
      if (ifa.uart_state) run_a++;
      else if (run_a != 0) begin
        len_a = run_a;
        run_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pb_prev = 1'b0;
      run_b   = 0;
    end else begin
      if (ifb.Rx_Done || ifb.frame_err) begin
        chk("b_pulse_excl", int'(ifb.Rx_Done & ifb.frame_err), 0);
        chk("b_pulse_width", int'(pb_prev), 0);
        if (q_b.size() == 0) chk("b_unexpected_pulse", 1, 0);
        else begin
          eb = q_b.pop_front();
          chk("b_kind_ferr", int'(ifb.frame_err), int'(eb.is_err));
          if (!eb.is_err) chk("b_data", int'(ifb.data_byte), int'(eb.data));
        end
      end
      pb_prev = ifb.Rx_Done | ifb.frame_err;
      if (ifb.uart_state) run_b++;
      else if (run_b != 0) begin
        len_b = run_b;
        run_b = 0;
      end
    end
  end

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) ifa.Rs232_Rx = v;
    else           ifb.Rs232_Rx = v;
  endtask

  // Drives one frame from a negedge; noise inverts a one-sample-wide window around sub-tick 12
  // plus a single-clock spike inside every data bit.
  task automatic send(input int inst, input logic [7:0] b, input real bit_cyc,
                      input logic stop, input bit noise);
    logic [9:0] fr;
    logic       v;
    int         prev, endc, rel;
    fr   = {stop, b, 1'b0};
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      endc = int'((k + 1) * bit_cyc);
      for (int c = prev; c < endc; c++) begin
        v   = fr[k];
        rel = c - prev;
        if (noise && k >= 1 && k <= 8 && ((rel >= 342 && rel < 369) || rel == 250)) v = ~v;
        set_line(inst, v);
        @(negedge clk);
      end
      prev = endc;
    end
    set_line(inst, 1'b1);
  endtask

  task automatic push(input int inst, input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    if (inst == 0) q_a.push_back(e);
    else           q_b.push_back(e);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.Rs232_Rx = 1'b0;   // line held low through reset must not start a frame
    ifa.baud_set = 3'd4;
    ifb.Rs232_Rx = 1'b1;
    ifb.baud_set = 3'd0;
    rst          = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_data", int'(ifa.data_byte), 0);
    chk("rst_a_done", int'(ifa.Rx_Done), 0);
    chk("rst_a_ferr", int'(ifa.frame_err), 0);
    chk("rst_a_state", int'(ifa.uart_state), 0);
    chk("rst_b_data", int'(ifb.data_byte), 0);
    chk("rst_b_state", int'(ifb.uart_state), 0);
    repeat (600) @(negedge clk);
    chk("low_line_no_frame", int'(ifa.uart_state), 0);
    ifa.Rs232_Rx = 1'b1;
    repeat (50) @(negedge clk);

    // back-to-back frames
    push(0, 1'b0, 8'h0C);
    push(0, 1'b0, 8'h37);
    send(0, 8'h0C, BIT_A, 1'b1, 1'b0);
    send(0, 8'h37, BIT_A, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    chk("b2b_data", int'(ifa.data_byte), 8'h37);

    // 3 us low glitch: aborts at start-bit tick 12
    ifa.Rs232_Rx = 1'b0;
    repeat (150) @(negedge clk);
    ifa.Rs232_Rx = 1'b1;
    repeat (500) @(negedge clk);
    chk_rng("glitch_busy_len", len_a, 12 * DIV_A, 14 * DIV_A);
    chk("glitch_hold_data", int'(ifa.data_byte), 8'h37);

    // stop bit low
    push(0, 1'b1, 8'h00);
    send(0, 8'h55, BIT_A, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    chk("ferr_hold_data", int'(ifa.data_byte), 8'h37);

    // reset during data bit 4 of 0xFF, then a clean frame
    fork
      send(0, 8'hFF, BIT_A, 1'b1, 1'b0);
      begin
        repeat (5 * BIT_A + BIT_A / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    chk("post_rst_data", int'(ifa.data_byte), 0);
    push(0, 1'b0, 8'h81);
    send(0, 8'h81, BIT_A, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    chk("post_rst_frame", int'(ifa.data_byte), 8'h81);

    // rate tolerance and noise
    push(0, 1'b0, 8'h3C);
    send(0, 8'h3C, BIT_A * 0.98, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    push(0, 1'b0, 8'h3C);
    send(0, 8'h3C, BIT_A * 1.02, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    push(0, 1'b0, 8'h3C);
    send(0, 8'h3C, BIT_A, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    chk("noise_data", int'(ifa.data_byte), 8'h3C);

    // rate sweep; baud_set is disturbed mid-frame to show it is latched at the start edge
    for (int s = 0; s < 5; s++) begin
      ifb.baud_set = 3'(s);
      push(1, 1'b0, 8'hA5);
      fork
        send(1, 8'hA5, 16 * div_b(s), 1'b1, 1'b0);
        begin
          repeat (40) @(negedge clk);
          ifb.baud_set = 3'(7 - s);
        end
      join
      repeat (30) @(negedge clk);
      chk("sweep_data", int'(ifb.data_byte), 8'hA5);
      chk_rng("sweep_busy_len", len_b, 155 * div_b(s), 158 * div_b(s) + 4);
    end

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Clk  in  1  system clock; all logic on rising edge.
REQ-003 Rst  in  1  reset, synchronous, active-high.
REQ-004 baud_set  in  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5-7=115200.
REQ-005 Rs232_Rx  in  1  asynchronous serial line, idle high.
REQ-006 data_byte  out  8  last received byte, LSB first on line; holds until next good frame.
REQ-007 Rx_Done  out  1  one-Clk pulse when a frame with valid stop bit completes.
REQ-008 frame_err  out  1  one-Clk pulse when the stop bit samples low.
REQ-009 uart_state  out  1  high while a frame is in progress.

Function
REQ-010 Rs232_Rx passes through a 2-FF synchronizer; a falling edge is detected between the 2nd and a 3rd FF stage.
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 Oversampling: 16 sample ticks per bit; tick period = CLK_FREQ/(baud*16) Clk cycles, integer-truncated (50 MHz, 115200 gives 27 cycles).
REQ-013 baud_set is latched at frame start; changes mid-frame have no effect until the next frame.
REQ-014 States: IDLE, RECV. IDLE -> RECV on the synchronized falling edge. uart_state = 1 in RECV.
REQ-015 In RECV, tick counter bps_cnt runs 0..159. Bit k (0=start, 1-8=data, 9=stop) occupies ticks 16k..16k+15.
REQ-016 Each bit takes 7 samples at sub-ticks 6..12 (7 tick strobes). The bit value is 1 when 4 or more samples are 1 (majority vote).
REQ-017 Start-bit check at tick 12: if the start majority is 1, the frame is a glitch. Abort to IDLE with no Rx_Done, no frame_err, and data_byte unchanged.
REQ-018 At the stop bit's tick 156 (sub-tick 12):
  - if the stop majority is 1: update data_byte and pulse Rx_Done on the next Clk;
  - if it is 0: pulse frame_err, data_byte unchanged;
  - in both cases return to IDLE on that same Clk, so a start edge is accepted immediately after.
REQ-019 Rx_Done and frame_err are never high together and are never high for more than one Clk.
REQ-020 A falling edge seen while in RECV is ignored.
REQ-021 A line held low at or after reset does not start a frame until a high-to-low transition is seen.

Reset
REQ-022 With Rst high on a Clk edge:
  - state = IDLE, bps_cnt = 0, divider = 0;
  - data_byte = 8'h00, Rx_Done = 0, frame_err = 0, uart_state = 0;
  - synchronizer FFs = 1.
REQ-023 Rst asserted mid-frame abandons the frame with no output pulse; reception resumes on the first falling edge after Rst deasserts.

Structure
REQ-024 Package uart_pkg holds:
  - the baud_set encoding constants;
  - the divisor function of (CLK_FREQ, baud, oversample);
  - OVERSAMPLE=16, SAMPLE_LO=6, SAMPLE_HI=12, FRAME_TICKS=160.
  uart_byte_tx uses the same package with oversample 1.
REQ-025 Sub-module uart_baud_gen (parameters CLK_FREQ and OVERSAMPLE; inputs enable and baud_set; output one-Clk tick strobe) produces the sample ticks. Its divider clears when enable is low.

Verification
REQ-026 CLK_FREQ=50 MHz, baud_set=4: send 8'h0C, then 8'h37 back to back (stop bit immediately followed by start) -> two Rx_Done pulses; data_byte = 8'h0C then 8'h37; frame_err never set.
REQ-027 Each baud_set 0-4: send 8'hA5 -> Rx_Done once; data_byte = 8'hA5; uart_state high for about 156 ticks.
REQ-028 Low glitch of 3 us on idle line at 115200 -> no Rx_Done, no frame_err, uart_state back to 0 by tick 13, data_byte unchanged.
REQ-029 Frame 8'h55 with stop bit driven 0 -> frame_err one-Clk pulse, no Rx_Done, data_byte keeps previous value.
REQ-030 Rst pulsed during data bit 4 of 8'hFF, then a clean 8'h81 -> no pulse for the first frame, Rx_Done with data_byte = 8'h81.
REQ-031 Transmitter 2% fast and 2% slow, plus 1-sample single-Clk noise spikes inside data bits -> 8'h3C received correctly each time.
